// File: rtl/hr_peak_tracker.sv
// Peak detector over a symmetric sample window with refractory/timeout gating,
// followed by a restoring divider that turns the inter-beat interval into bpm.
module hr_peak_tracker #(
  parameter int DATA_W       = 9,
  parameter int HALF_WIN     = 16,
  parameter int CNT_W        = 11,
  parameter int RATE         = 100,
  parameter int MIN_INTERVAL = 30,
  parameter int MAX_INTERVAL = 300,
  parameter int DIV_W        = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak,
  output logic [CNT_W-1:0]         interval,
  output logic                     interval_valid,
  output logic [7:0]               bpm,
  output logic                     bpm_valid,
  output logic                     busy,
  output logic                     timeout
);

  localparam int L      = 2 * HALF_WIN + 1;
  localparam int FILL_W = $clog2(L + 1);
  localparam int IT_W   = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] NUM   = DIV_W'(60 * RATE);
  localparam logic [CNT_W:0]   MIN_C = (CNT_W + 1)'(MIN_INTERVAL);
  localparam logic [CNT_W:0]   MAX_C = (CNT_W + 1)'(MAX_INTERVAL);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  logic signed [DATA_W-1:0] win  [L];
  logic signed [DATA_W-1:0] nwin [L];
  logic [FILL_W-1:0] fill, fill_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    c;
  logic              first_seen;
  logic              is_max, candidate, accept, tmo, start;

  state_t            state;
  logic [IT_W-1:0]   iter;
  logic [CNT_W-1:0]  rem, dvsr, rem_next;
  logic [DIV_W-1:0]  quo;
  logic [CNT_W:0]    trial;
  logic              q_bit;

  // Evaluation sees the window as it will be after this strobe's shift.
  always_comb begin
    nwin[0] = sample;
    for (int i = 1; i < L; i++) nwin[i] = win[i-1];
    is_max = 1'b1;
    for (int i = 0; i < L; i++)
      if (i != HALF_WIN && !(nwin[HALF_WIN] > nwin[i])) is_max = 1'b0;
    fill_next = (fill == FILL_W'(L)) ? fill : fill + FILL_W'(1);
    candidate = (fill_next == FILL_W'(L)) && is_max && (nwin[HALF_WIN] > threshold);
    c         = {1'b0, cnt} + (CNT_W + 1)'(1);
    accept    = sample_valid && candidate && (!first_seen || c >= MIN_C);
    tmo       = sample_valid && !accept && first_seen && (c >= MAX_C);
    start     = accept && first_seen;
  end

  always_comb begin
    trial    = {rem, quo[DIV_W-1]};
    q_bit    = (trial >= {1'b0, dvsr});
    rem_next = q_bit ? CNT_W'(trial - {1'b0, dvsr}) : trial[CNT_W-1:0];
  end

  // Window contents need no reset: the fill counter gates evaluation.
  always_ff @(posedge clock) begin
    if (sample_valid) win <= nwin;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill           <= '0;
      cnt            <= '0;
      first_seen     <= 1'b0;
      peak           <= 1'b0;
      interval       <= '0;
      interval_valid <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      peak           <= 1'b0;
      interval_valid <= 1'b0;
      timeout        <= 1'b0;
      if (sample_valid) begin
        fill <= fill_next;
        if (accept) begin
          peak       <= 1'b1;
          cnt        <= '0;
          first_seen <= 1'b1;
          if (first_seen) begin
            interval       <= c[CNT_W-1:0];
            interval_valid <= 1'b1;
          end
        end else if (tmo) begin
          timeout    <= 1'b1;
          cnt        <= '0;
          first_seen <= 1'b0;
        end else begin
          cnt <= (c >= MAX_C) ? MAX_C[CNT_W-1:0] : c[CNT_W-1:0];
        end
      end
    end
  end

  // Timeout aborts any division; a new start restarts it from iteration 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= '0;
      rem       <= '0;
      dvsr      <= '0;
      quo       <= '0;
      busy      <= 1'b0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
    end else begin
      bpm_valid <= 1'b0;
      if (tmo) begin
        state     <= IDLE;
        busy      <= 1'b0;
        bpm       <= '0;
        bpm_valid <= 1'b1;
      end else if (start) begin
        state <= DIV;
        busy  <= 1'b1;
        iter  <= '0;
        rem   <= '0;
        quo   <= NUM;
        dvsr  <= c[CNT_W-1:0];
      end else begin
        case (state)
          DIV: begin
            rem  <= rem_next;
            quo  <= {quo[DIV_W-2:0], q_bit};
            iter <= iter + IT_W'(1);
            if (iter == IT_W'(DIV_W - 1)) state <= DONE;
          end
          DONE: begin
            bpm       <= (quo > DIV_W'(255)) ? 8'hFF : quo[7:0];
            bpm_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hr_peak_tracker.sv
// Directed bench for hr_peak_tracker: default instance plus a MIN_INTERVAL=1 instance.
module tb_hr_peak_tracker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset = 1'b1, sample_valid = 1'b0;
  logic signed [8:0] sample = '0, threshold = 9'sd10;
  logic              peak, interval_valid, bpm_valid, busy, timeout;
  logic [10:0]       interval;
  logic [7:0]        bpm;

  logic              b_reset = 1'b1, b_valid = 1'b0;
  logic signed [8:0] b_sample = '0, b_threshold = 9'sd10;
  logic              b_peak, b_iv, b_bv, b_busy, b_timeout;
  logic [10:0]       b_interval;
  logic [7:0]        b_bpm;

  hr_peak_tracker dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .threshold(threshold), .peak(peak), .interval(interval),
    .interval_valid(interval_valid), .bpm(bpm), .bpm_valid(bpm_valid),
    .busy(busy), .timeout(timeout)
  );

  hr_peak_tracker #(.MIN_INTERVAL(1)) dut_b (
    .clock(clock), .reset(b_reset), .sample_valid(b_valid), .sample(b_sample),
    .threshold(b_threshold), .peak(b_peak), .interval(b_interval),
    .interval_valid(b_iv), .bpm(b_bpm), .bpm_valid(b_bv),
    .busy(b_busy), .timeout(b_timeout)
  );

  int total = 0, bad = 0, sidx = 0, cyc = 0;
  int peak_n = 0, iv_n = 0, bv_n = 0, to_n = 0, iv_cyc = 0, bv_cyc = 0, viol = 0;
  int b_iv_n = 0, b_bv_n = 0;
  logic [10:0] last_iv = '0;
  logic [7:0]  prev_bpm;

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (peak) peak_n++;
      if (interval_valid) begin iv_n++; last_iv = interval; iv_cyc = cyc; if (!busy) viol++; end
      if (bpm_valid) begin bv_n++; bv_cyc = cyc; if (busy) viol++; end
      if (timeout) begin to_n++; if (!bpm_valid) viol++; end
      if (bpm != prev_bpm && !bpm_valid) viol++;
    end
    prev_bpm = bpm;
    if (b_iv) b_iv_n++;
    if (b_bv) b_bv_n++;
  end

  task automatic strobe(input bit sel, input int v);
    @(posedge clock); #1;
    if (sel) begin b_sample = 9'(v); b_valid = 1'b1; end
    else begin sample = 9'(v); sample_valid = 1'b1; end
    @(posedge clock); #1;
    b_valid = 1'b0; sample_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    sidx++;
  endtask

  task automatic feed_to(input bit sel, input int n);
    while (sidx < n) strobe(sel, 0);
  endtask

  task automatic do_reset(input bit sel);
    @(posedge clock); #1;
    if (sel) b_reset = 1'b1; else reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    b_reset = 1'b0; reset = 1'b0;
    sidx = 0;
  endtask

  task automatic test_reset();
    int p0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      sample_valid = 1'($urandom_range(0, 1));
      sample = 9'($urandom);
    end
    sample_valid = 1'b0;
    @(negedge clock);
    total++; if (peak !== 1'b0) begin bad++; $display("FAIL reset_peak: got %b want 0", peak); end
    total++; if (interval_valid !== 1'b0) begin bad++; $display("FAIL reset_iv: got %b want 0", interval_valid); end
    total++; if (bpm_valid !== 1'b0) begin bad++; $display("FAIL reset_bv: got %b want 0", bpm_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    total++; if (interval !== 11'd0) begin bad++; $display("FAIL reset_interval: got %0d want 0", interval); end
    total++; if (bpm !== 8'd0) begin bad++; $display("FAIL reset_bpm: got %0d want 0", bpm); end
    @(posedge clock); #1;
    reset = 1'b0;
    sidx = 0;
    p0 = peak_n;
    feed_to(0, 15);
    strobe(0, 100);
    feed_to(0, 40);
    total++; if (peak_n - p0 !== 0) begin bad++; $display("FAIL fill_gate: got %0d peaks want 0", peak_n - p0); end
  endtask

  task automatic test_impulse_train();
    int p0, i0, b0;
    do_reset(0);
    threshold = 9'sd10;
    p0 = peak_n; i0 = iv_n; b0 = bv_n;
    feed_to(0, 20); strobe(0, 100); feed_to(0, 50);
    total++; if (peak_n - p0 !== 1) begin bad++; $display("FAIL first_peak: got %0d want 1", peak_n - p0); end
    total++; if (iv_n - i0 !== 0) begin bad++; $display("FAIL first_no_iv: got %0d want 0", iv_n - i0); end
    feed_to(0, 70); strobe(0, 100); feed_to(0, 100);
    total++; if (iv_n - i0 !== 1) begin bad++; $display("FAIL second_iv: got %0d want 1", iv_n - i0); end
    total++; if (last_iv !== 11'd50) begin bad++; $display("FAIL interval_50: got %0d want 50", last_iv); end
    total++; if (bpm !== 8'd120) begin bad++; $display("FAIL bpm_120: got %0d want 120", bpm); end
    total++; if (bv_n - b0 !== 1) begin bad++; $display("FAIL bv_count: got %0d want 1", bv_n - b0); end
    total++; if (bv_cyc - iv_cyc !== 17) begin bad++; $display("FAIL div_latency: got %0d want 17", bv_cyc - iv_cyc); end
    feed_to(0, 120); strobe(0, 100);
    feed_to(0, 191); strobe(0, 100); feed_to(0, 240);
    total++; if (peak_n - p0 !== 4) begin bad++; $display("FAIL train_peaks: got %0d want 4", peak_n - p0); end
    total++; if (iv_n - i0 !== 3) begin bad++; $display("FAIL train_iv: got %0d want 3", iv_n - i0); end
    total++; if (last_iv !== 11'd71) begin bad++; $display("FAIL interval_71: got %0d want 71", last_iv); end
    total++; if (bpm !== 8'd84) begin bad++; $display("FAIL bpm_84: got %0d want 84", bpm); end
  endtask

  // Continues from the impulse train: last accept was at strobe 207.
  task automatic test_timeout();
    int t0, b0, p0, i0;
    t0 = to_n; b0 = bv_n;
    feed_to(0, 507);
    total++; if (to_n - t0 !== 0) begin bad++; $display("FAIL early_timeout: got %0d want 0", to_n - t0); end
    total++; if (bpm !== 8'd84) begin bad++; $display("FAIL bpm_held: got %0d want 84", bpm); end
    strobe(0, 0);
    total++; if (to_n - t0 !== 1) begin bad++; $display("FAIL timeout_pulse: got %0d want 1", to_n - t0); end
    total++; if (bv_n - b0 !== 1) begin bad++; $display("FAIL timeout_bv: got %0d want 1", bv_n - b0); end
    total++; if (bpm !== 8'd0) begin bad++; $display("FAIL timeout_bpm: got %0d want 0", bpm); end
    p0 = peak_n; i0 = iv_n;
    strobe(0, 100); feed_to(0, 540);
    total++; if (peak_n - p0 !== 1) begin bad++; $display("FAIL post_to_peak: got %0d want 1", peak_n - p0); end
    total++; if (iv_n - i0 !== 0) begin bad++; $display("FAIL post_to_iv: got %0d want 0", iv_n - i0); end
  endtask

  task automatic test_plateau_threshold();
    int p0;
    do_reset(0);
    p0 = peak_n;
    feed_to(0, 20); strobe(0, 100); strobe(0, 100); feed_to(0, 60);
    total++; if (peak_n - p0 !== 0) begin bad++; $display("FAIL plateau: got %0d want 0", peak_n - p0); end
    strobe(0, 8); feed_to(0, 100);
    total++; if (peak_n - p0 !== 0) begin bad++; $display("FAIL below_thr: got %0d want 0", peak_n - p0); end
    strobe(0, 10); feed_to(0, 140);
    total++; if (peak_n - p0 !== 0) begin bad++; $display("FAIL equal_thr: got %0d want 0", peak_n - p0); end
    strobe(0, 11); feed_to(0, 180);
    total++; if (peak_n - p0 !== 1) begin bad++; $display("FAIL above_thr: got %0d want 1", peak_n - p0); end
  endtask

  task automatic test_refractory();
    int p0, i0;
    do_reset(0);
    p0 = peak_n; i0 = iv_n;
    feed_to(0, 20); strobe(0, 100);
    feed_to(0, 70); strobe(0, 100);
    feed_to(0, 90); strobe(0, 100);
    feed_to(0, 120); strobe(0, 100); feed_to(0, 150);
    total++; if (peak_n - p0 !== 3) begin bad++; $display("FAIL refr_peaks: got %0d want 3", peak_n - p0); end
    total++; if (iv_n - i0 !== 2) begin bad++; $display("FAIL refr_iv: got %0d want 2", iv_n - i0); end
    total++; if (last_iv !== 11'd50) begin bad++; $display("FAIL refr_interval: got %0d want 50", last_iv); end
    total++; if (bpm !== 8'd120) begin bad++; $display("FAIL refr_bpm: got %0d want 120", bpm); end
  endtask

  task automatic test_saturation_abort();
    int i0, b0;
    do_reset(1);
    i0 = b_iv_n;
    feed_to(1, 20); strobe(1, 100);
    feed_to(1, 40); strobe(1, 100); feed_to(1, 60);
    total++; if (b_iv_n - i0 !== 1) begin bad++; $display("FAIL sat_iv: got %0d want 1", b_iv_n - i0); end
    total++; if (b_interval !== 11'd20) begin bad++; $display("FAIL sat_interval: got %0d want 20", b_interval); end
    total++; if (b_bpm !== 8'd255) begin bad++; $display("FAIL sat_bpm: got %0d want 255", b_bpm); end
    strobe(1, 100); feed_to(1, 76);
    b0 = b_bv_n;
    @(posedge clock); #1; b_valid = 1'b1; b_sample = '0;
    @(posedge clock); #1; b_valid = 1'b0;
    total++; if (b_iv !== 1'b1) begin bad++; $display("FAIL abort_iv: got %b want 1", b_iv); end
    repeat (5) @(posedge clock);
    #1;
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre: got %b want 1", b_busy); end
    b_reset = 1'b1;
    @(posedge clock); #1; b_reset = 1'b0;
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", b_busy); end
    total++; if (b_bpm !== 8'd0) begin bad++; $display("FAIL abort_bpm: got %0d want 0", b_bpm); end
    repeat (30) @(posedge clock);
    #1;
    total++; if (b_bv_n - b0 !== 0) begin bad++; $display("FAIL abort_no_bv: got %0d want 0", b_bv_n - b0); end
  endtask

  initial begin
    b_reset = 1'b1;
    test_reset();
    test_impulse_train();
    test_timeout();
    test_plateau_threshold();
    test_refractory();
    test_saturation_abort();
    total++; if (viol !== 0) begin bad++; $display("FAIL handshake_rules: got %0d violations want 0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
